// File: rtl/mac_array_ctrl_pkg.sv
// Shared types and default sizing for the mac_array tile sequencer.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } mac_ctrl_state_t;

  localparam int DEF_ARRAY_SIZE             = 2;
  localparam int DEF_COMPUTE_DATA_WIDTH     = 4;
  localparam int DEF_ACCUMULATOR_DATA_WIDTH = 16;
  localparam int DEF_MAX_K                  = 256;

  // Lane index width; a single-lane array still gets a 1-bit index.
  function automatic int lane_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for one mac_array: clear, weight load, K activation beats,
// then a lane-by-lane drain of the accumulators. No arithmetic lives here.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE             = DEF_ARRAY_SIZE,
  parameter int COMPUTE_DATA_WIDTH     = DEF_COMPUTE_DATA_WIDTH,
  parameter int ACCUMULATOR_DATA_WIDTH = DEF_ACCUMULATOR_DATA_WIDTH,
  parameter int MAX_K                  = DEF_MAX_K,
  localparam int K_WIDTH               = $clog2(MAX_K + 1),
  localparam int LANE_WIDTH            = lane_width(ARRAY_SIZE)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic [K_WIDTH-1:0]                                 k_len,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               err_zero_len,
  input  logic                                               weight_valid,
  output logic                                               weight_ready,
  input  logic                                               act_valid,
  output logic                                               act_ready,
  output logic                                               mac_clear,
  output logic                                               mac_load_en,
  output logic                                               mac_compute,
  input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]  acc_in,
  output logic                                               res_valid,
  input  logic                                               res_ready,
  output logic [LANE_WIDTH-1:0]                              res_lane,
  output logic [ACCUMULATOR_DATA_WIDTH-1:0]                  res_data
);

  localparam logic [K_WIDTH-1:0]    MAX_K_L   = K_WIDTH'(MAX_K);
  localparam logic [K_WIDTH-1:0]    K_ONE     = K_WIDTH'(1);
  localparam logic [LANE_WIDTH-1:0] LANE_ONE  = LANE_WIDTH'(1);
  localparam logic [LANE_WIDTH-1:0] LANE_LAST = LANE_WIDTH'(ARRAY_SIZE - 1);

  // The operand width only has to match the array instance; reject nonsense.
  if (COMPUTE_DATA_WIDTH < 1 || MAX_K < 1 || ARRAY_SIZE < 1) begin : g_bad_param
    $error("mac_array_ctrl: widths, MAX_K and ARRAY_SIZE must be positive");
  end

  mac_ctrl_state_t             state_q, state_d;
  logic [K_WIDTH-1:0]          k_q, k_d;
  logic [K_WIDTH-1:0]          cnt_q, cnt_d;
  logic [LANE_WIDTH-1:0]       lane_q, lane_d;
  logic                        err_q, err_d;
  logic                        k_legal;

  assign k_legal = (k_len != '0) && (k_len <= MAX_K_L);

  // Next-state logic: tile sequencing, beat counting and drain lane stepping.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (k_legal) begin
            k_d     = k_len;
            cnt_d   = '0;
            state_d = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = LOAD;
      LOAD: begin
        if (weight_valid) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (act_valid) begin
          cnt_d = cnt_q + K_ONE;
          // Last beat lands in the accumulator on this same edge, so go
          // straight to DRAIN without a bubble.
          if (cnt_q == k_q - K_ONE) begin
            state_d = DRAIN;
            lane_d  = '0;
          end
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (lane_q == LANE_LAST) state_d = DONE;
          else                     lane_d  = lane_q + LANE_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state; an asynchronous reset drops any tile in flight silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
    end
  end

  // Handshakes and array strobes decode from state so a strobe coincides
  // with the handshake that it accepts.
  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    err_zero_len = err_q;
    mac_clear    = (state_q == CLEAR);
    weight_ready = (state_q == LOAD);
    mac_load_en  = weight_ready & weight_valid;
    act_ready    = (state_q == COMPUTE);
    mac_compute  = act_ready & act_valid;
    res_valid    = (state_q == DRAIN);
    res_lane     = res_valid ? lane_q : '0;
    res_data     = res_valid ? acc_in[lane_q] : '0;
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: the driver predicts the event stream
// of each tile, a negedge monitor pops and compares whatever the DUT emits.
module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  localparam int AS   = 2;
  localparam int ACCW = 16;
  localparam int MAXK = 256;
  localparam int KW   = $clog2(MAXK + 1);
  localparam int LW   = 1;

  // event kind bits
  localparam logic [5:0] EV_CLR  = 6'd1;
  localparam logic [5:0] EV_LOAD = 6'd2;
  localparam logic [5:0] EV_CMP  = 6'd4;
  localparam logic [5:0] EV_RES  = 6'd8;
  localparam logic [5:0] EV_DONE = 6'd16;
  localparam logic [5:0] EV_ERR  = 6'd32;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [KW-1:0] k_len;
  logic busy, done, err_zero_len;
  logic weight_valid, weight_ready, act_valid, act_ready;
  logic mac_clear, mac_load_en, mac_compute;
  logic [AS-1:0][ACCW-1:0] acc_in;
  logic res_valid, res_ready;
  logic [LW-1:0] res_lane;
  logic [ACCW-1:0] res_data;

  mac_array_ctrl #(
    .ARRAY_SIZE(AS), .COMPUTE_DATA_WIDTH(4), .ACCUMULATOR_DATA_WIDTH(ACCW), .MAX_K(MAXK)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .err_zero_len(err_zero_len), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .act_valid(act_valid), .act_ready(act_ready), .mac_clear(mac_clear),
    .mac_load_en(mac_load_en), .mac_compute(mac_compute), .acc_in(acc_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_lane(res_lane), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;
  int start_cyc = 0;

  typedef struct {
    logic [5:0]      kind;
    int              lane;
    logic [ACCW-1:0] data;
    int              rel;
  } ev_t;

  ev_t exp_q[$];
  logic [ACCW-1:0] acc_m[AS];
  bit act_pat[64];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic ev_t mk(input logic [5:0] kind, input int lane,
                             input logic [ACCW-1:0] data, input int rel);
    ev_t e;
    e.kind = kind; e.lane = lane; e.data = data; e.rel = rel;
    return e;
  endfunction

  function automatic logic [23:0] all_outs();
    return {busy, done, err_zero_len, weight_ready, act_ready, mac_clear,
            mac_load_en, mac_compute, res_valid, res_lane, res_data};
  endfunction

  // Monitor
  logic [5:0] mon_k;
  ev_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      mon_k = {err_zero_len, done, res_valid & res_ready, mac_compute, mac_load_en, mac_clear};
      if (!busy)
        check("idle_quiet", {weight_ready, act_ready, mac_clear, mac_load_en, mac_compute,
                             res_valid, res_lane, res_data, done}, 0);
      if (mon_k != 6'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", mon_k, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", mon_k, mon_e.kind);
          if (mon_e.kind == EV_RES) begin
            check("res_lane", res_lane, mon_e.lane);
            check("res_data", res_data, mon_e.data);
          end
          if (mon_e.kind == EV_LOAD) check("weight_ready_on_load", weight_ready, 1);
          if (mon_e.kind == EV_CMP)  check("act_ready_on_compute", act_ready, 1);
          if (mon_e.rel >= 0) check("event_cycle", cyc - start_cyc, mon_e.rel);
        end
      end
    end
  end

  task automatic idle_inputs();
    start = 1'b0; weight_valid = 1'b0; act_valid = 1'b0; res_ready = 1'b0;
  endtask

  // mode 0: weight/res always ready, act_valid from act_pat, fully timed.
  // mode 1: random valid/ready, order-only checking.
  task automatic run_tile(input int k, input int mode, input int drain_stall, input int abort_after);
    int n, t, r, ds_left, abort_rel;
    bit legal, timed;
    n = 0;
    while (busy) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin check("wait_idle_timeout", n, 0); return; end
    end
    for (int i = 0; i < AS; i++) begin
      acc_m[i]  = ACCW'($urandom);
      acc_in[i] = acc_m[i];
    end
    legal = (k >= 1) && (k <= MAXK);
    timed = (mode == 0);
    k_len = k[KW-1:0];
    start = 1'b1;
    weight_valid = 1'b0; act_valid = 1'b0; res_ready = 1'b0;
    start_cyc = cyc;
    if (!legal) begin
      exp_q.push_back(mk(EV_ERR, 0, '0, 1));
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_err", busy, 0);
      end
      return;
    end
    exp_q.push_back(mk(EV_CLR, 0, '0, 1));
    exp_q.push_back(mk(EV_LOAD, 0, '0, timed ? 2 : -1));
    t = 3;
    abort_rel = -1;
    for (int i = 0; i < k; i++) begin
      while (t - 3 < 64 && act_pat[t - 3] == 1'b0) t++;
      if (abort_after == 0 || i < abort_after)
        exp_q.push_back(mk(EV_CMP, 0, '0, timed ? t : -1));
      if (abort_after > 0 && i == abort_after - 1) abort_rel = t + 1;
      t++;
    end
    if (abort_after == 0) begin
      for (int i = 0; i < AS; i++)
        exp_q.push_back(mk(EV_RES, i, acc_m[i], timed ? t + drain_stall + i : -1));
      exp_q.push_back(mk(EV_DONE, 0, '0, timed ? t + drain_stall + AS : -1));
    end
    ds_left = drain_stall;
    r = 0;
    forever begin
      @(posedge clk); #1;
      r++;
      start = 1'b0;
      if (r == abort_rel) begin
        #1 rst = 1'b0;
        #1;
        check("abort_outputs_zero", all_outs(), 0);
        check("abort_scoreboard_drained", exp_q.size(), 0);
        idle_inputs();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      if (done) begin
        idle_inputs();
        return;
      end
      if (r > 2000) begin
        check("tile_timeout", r, 0);
        idle_inputs();
        return;
      end
      if (mode == 0) begin
        weight_valid = 1'b1;
        act_valid    = (r >= 3 && r - 3 < 64) ? act_pat[r - 3] : 1'b1;
        res_ready    = 1'b1;
        if (res_valid && ds_left > 0) begin
          res_ready = 1'b0;
          check("stall_lane", res_lane, 0);
          check("stall_data", res_data, acc_m[0]);
          ds_left--;
        end
      end else begin
        weight_valid = $urandom_range(0, 1) == 1;
        act_valid    = $urandom_range(0, 1) == 1;
        res_ready    = $urandom_range(0, 2) != 0;
      end
    end
  endtask

  task automatic pat_ones();
    for (int i = 0; i < 64; i++) act_pat[i] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, mode, ds;
    rst = 1'b0;
    k_len = '0;
    acc_in = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_outputs", all_outs(), 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_reset_outputs", all_outs(), 0);
    end

    // nominal k=3 tile, no stalls
    pat_ones();
    run_tile(3, 0, 0, 0);
    // act_valid toggling 1,0,1,0,1
    for (int i = 0; i < 64; i++) act_pat[i] = (i < 5) ? ((i % 2) == 0) : 1'b1;
    run_tile(3, 0, 0, 0);
    // drain held off for 4 cycles
    pat_ones();
    run_tile(3, 0, 4, 0);
    // illegal lengths
    run_tile(0, 0, 0, 0);
    run_tile(MAXK + 1, 0, 0, 0);
    // reset during compute, then a fresh k=1 tile
    run_tile(5, 0, 0, 2);
    run_tile(1, 0, 0, 0);
    // longest legal tile
    run_tile(MAXK, 1, 0, 0);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 7) == 0)
        k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXK + 1, (1 << KW) - 1);
      else
        k = $urandom_range(1, 12);
      mode = $urandom_range(0, 1);
      ds = $urandom_range(0, 3);
      for (int i = 0; i < 64; i++) act_pat[i] = $urandom_range(0, 9) < 7;
      run_tile(k, mode, (mode == 0) ? ds : 0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
